// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline-stage register with skid buffer, flush and occupancy count
module pipe_stage_buf #(
  parameter int                 WIDTH      = 200,
  parameter int                 DEPTH      = 2,
  parameter logic [WIDTH-1:0]   BUBBLE_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Handshake outputs depend only on registered occupancy, never on out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE_VAL;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf at DEPTH 2, 4 and 8
module tb_pipe_stage_buf;

  localparam int          W   = 16;
  localparam logic [15:0] BUB = 16'hDEAD;
  localparam int          DEP [3] = '{2, 4, 8};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [3];
  logic        ordy [3];
  logic        fl   [3];
  logic [15:0] id   [3];
  logic        irdy [3];
  logic        ov   [3];
  logic [15:0] od   [3];
  logic [3:0]  cnt  [3];
  logic [1:0]  cnt0;
  logic [2:0]  cnt1;
  logic [3:0]  cnt2;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] q [3][$];

  always #5 clk = ~clk;

  assign cnt[0] = 4'(cnt0);
  assign cnt[1] = 4'(cnt1);
  assign cnt[2] = cnt2;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(2), .BUBBLE_VAL(BUB)) u_d2 (
    .clk(clk), .reset(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .count(cnt0));
  pipe_stage_buf #(.WIDTH(W), .DEPTH(4), .BUBBLE_VAL(BUB)) u_d4 (
    .clk(clk), .reset(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .count(cnt1));
  pipe_stage_buf #(.WIDTH(W), .DEPTH(8), .BUBBLE_VAL(BUB)) u_d8 (
    .clk(clk), .reset(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .count(cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an ordered queue of accepted words, bounded by DEPTH.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fl[i]) begin
          q[i].delete();
        end else begin
          bit can_push, do_push, do_pop;
          can_push = (q[i].size() != DEP[i]);
          do_push  = iv[i] && can_push;
          do_pop   = (q[i].size() != 0) && ordy[i];
          if (do_pop)  void'(q[i].pop_front());
          if (do_push) q[i].push_back(id[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d_count", i), 32'(cnt[i]), 32'(q[i].size()));
        chk($sformatf("m%0d_out_valid", i), 32'(ov[i]), 32'(q[i].size() != 0));
        chk($sformatf("m%0d_in_ready", i), 32'(irdy[i]), 32'(q[i].size() != DEP[i]));
        chk($sformatf("m%0d_out_data", i), 32'(od[i]), (q[i].size() != 0) ? 32'(q[i][0]) : 32'(BUB));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] rx [$];
  logic [15:0] word;
  int          sent;
  int          steps;
  bit          acc;

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; ordy[i] = 0; fl[i] = 0; id[i] = '0;
    end
    cyc(); cyc();
    rst = 1'b0;

    // 1: asynchronous reset mid-stream
    iv[0] = 1; id[0] = 16'h000A; cyc();
    id[0] = 16'h000B; cyc();
    iv[0] = 0;
    #1;
    chk("t1_count_before", 32'(cnt0), 32'd2);
    rst = 1'b1;
    #1;
    chk("t1_out_valid", 32'(ov[0]), 32'd0);
    chk("t1_count", 32'(cnt0), 32'd0);
    chk("t1_out_data", 32'(od[0]), 32'(BUB));
    chk("t1_in_ready", 32'(irdy[0]), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();

    // 2: pass-through, one-cycle latency
    ordy[0] = 1;
    iv[0] = 1; id[0] = 16'h0011; cyc();
    chk("t2_data_11", 32'(od[0]), 32'h11);
    chk("t2_count_1", 32'(cnt0), 32'd1);
    id[0] = 16'h0022; cyc();
    chk("t2_data_22", 32'(od[0]), 32'h22);
    chk("t2_count_2", 32'(cnt0), 32'd1);
    chk("t2_in_ready", 32'(irdy[0]), 32'd1);
    id[0] = 16'h0033; cyc();
    chk("t2_data_33", 32'(od[0]), 32'h33);
    iv[0] = 0; cyc();
    chk("t2_empty", 32'(ov[0]), 32'd0);
    ordy[0] = 0;

    // 3: backpressure to full on DEPTH=4
    iv[1] = 1;
    for (int k = 1; k <= 6; k++) begin
      id[1] = 16'(k);
      cyc();
      chk("t3_head_held", 32'(od[1]), 32'd1);
    end
    chk("t3_count_full", 32'(cnt1), 32'd4);
    chk("t3_in_ready", 32'(irdy[1]), 32'd0);

    // 4: full with simultaneous pop refuses the push
    id[1] = 16'd7; ordy[1] = 1; cyc();
    chk("t4_count_3", 32'(cnt1), 32'd3);
    chk("t4_head_2", 32'(od[1]), 32'd2);
    cyc();
    chk("t4_count_still_3", 32'(cnt1), 32'd3);
    chk("t4_head_3", 32'(od[1]), 32'd3);
    iv[1] = 0; cyc();
    chk("t4_head_4", 32'(od[1]), 32'd4);
    cyc();
    chk("t4_head_7", 32'(od[1]), 32'd7);
    cyc();
    chk("t4_drained", 32'(ov[1]), 32'd0);
    ordy[1] = 0;

    // 5: flush beats concurrent push and pop
    iv[0] = 1; id[0] = 16'h0055; cyc();
    id[0] = 16'h0066; cyc();
    chk("t5_count_2", 32'(cnt0), 32'd2);
    id[0] = 16'h0077; ordy[0] = 1; fl[0] = 1; cyc();
    fl[0] = 0; iv[0] = 0;
    chk("t5_count", 32'(cnt0), 32'd0);
    chk("t5_out_valid", 32'(ov[0]), 32'd0);
    chk("t5_out_data", 32'(od[0]), 32'(BUB));
    chk("t5_in_ready", 32'(irdy[0]), 32'd1);
    cyc();
    chk("t5_no_ghost", 32'(ov[0]), 32'd0);
    ordy[0] = 0;

    // 6: wrap-around on DEPTH=8 with random backpressure
    sent = 0; steps = 0;
    while (sent < 20 && steps < 300) begin
      iv[2] = 1; id[2] = 16'h0100 + 16'(sent);
      ordy[2] = 1'($urandom_range(0, 1));
      acc = irdy[2];
      if (ov[2] && ordy[2]) rx.push_back(od[2]);
      cyc();
      if (acc) sent++;
      steps++;
    end
    iv[2] = 0;
    chk("t6_all_sent", 32'(sent), 32'd20);
    steps = 0;
    while (ov[2] && steps < 50) begin
      ordy[2] = 1;
      rx.push_back(od[2]);
      cyc();
      steps++;
    end
    ordy[2] = 0;
    chk("t6_rx_len", 32'(rx.size()), 32'd20);
    for (int k = 0; k < 20; k++) begin
      word = (k < rx.size()) ? rx[k] : 16'hxxxx;
      chk($sformatf("t6_word_%0d", k), 32'(word), 32'h100 + 32'(k));
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
